registers_block: RTL and testbench
==================================

// Module: registers_block
// PURPOSE
//   MIPS general-purpose register file for the single-cycle datapath.
//   32 x 32-bit registers, two asynchronous read ports (rs/rt operands) and one synchronous write port (rd/rt result).
//   Register 0 ($zero) always reads 0.
//   Sits between instruction decode (register addresses) and the ALU/writeback mux.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the data ports
//   ADDR_WIDTH  5   register address width; depth = 2**ADDR_WIDTH (32)
// PORTS
//   clk        in   1           single clock; writes on rising edge
//   rst        in   1           asynchronous, active-high reset
//   WE         in   1           write enable, sampled on rising clk
//   ReadReg1   in   ADDR_WIDTH  read port 1 address
//   ReadReg2   in   ADDR_WIDTH  read port 2 address
//   WriteReg   in   ADDR_WIDTH  write address
//   WriteData  in   DATA_WIDTH  write data
//   ReadData1  out  DATA_WIDTH  contents of register ReadReg1
//   ReadData2  out  DATA_WIDTH  contents of register ReadReg2
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-high (rst).
//   - Reset:
//       - rst=1 clears all registers to 0 immediately, with no dependence on clk.
//       - While rst=1, both read outputs are therefore 0 for any address.
//       - Writes are blocked while rst=1.
//       - The first write after release happens on the first rising edge with rst=0.
//   - Write:
//       - On posedge clk with rst=0 and WE=1 and WriteReg!=0: reg[WriteReg] <= WriteData.
//       - WE=0 means no register changes.
//   - $zero:
//       - Writes to WriteReg=0 are discarded.
//       - ReadRegN=0 returns 0 regardless of storage contents. Storage of entry 0 is never written.
//   - Read:
//       - Purely combinational: ReadDataN = reg[ReadRegN] with zero clock latency.
//       - Address changes propagate to the output in the same cycle.
//   - Read-during-write, same address in the same cycle:
//       - Before the edge, the output shows the old value.
//       - After the edge, it shows the new value.
//       - No internal bypass; the datapath does not need one in single-cycle operation.
//   - Both read ports are independent. They may address the same or different registers simultaneously.
//   - Reset mid-operation: an rst assertion between edges clears contents at once. A pending write is lost.
//   - Widths: addresses are used unsigned and all 2**ADDR_WIDTH values are legal. There are no out-of-range cases.
//   - No X propagation after reset: every entry is defined.
// STRUCTURE
//   - Shared package (mips_pkg): REG_ADDR_W=5, REG_DATA_W=32, localparam ZERO_REG=5'd0.
//   - Single module; storage as an array of DATA_WIDTH vectors.
//   - One always block with posedge clk / posedge rst for the array.
//   - Two continuous-assign read muxes with the zero-register override.
//   - No sub-module needed. Optional: a read-port sub-module (regfile_read_port) instantiated twice, if the team prefers symmetry.
// TESTING
//   1. Reset:
//        - Assert rst, release it.
//        - Read all 32 addresses on both ports -> all 0x00000000.
//   2. Write/read r1:
//        - WE=1, WriteReg=1, WriteData=0xA5A5A5A5 across a rising edge.
//        - Then WE=0, ReadReg1=1 -> ReadData1=0xA5A5A5A5.
//   3. Write/read r2:
//        - WE=1, WriteReg=2, WriteData=0x5A5A5A5A, then WE=0.
//        - ReadReg2=2 -> ReadData2=0x5A5A5A5A.
//        - r1 is unchanged at 0xA5A5A5A5.
//   4. $zero:
//        - WE=1, WriteReg=0, WriteData=0xFFFFFFFF across an edge.
//        - ReadReg1=0 -> ReadData1=0x00000000.
//   5. Dual read: ReadReg1=1, ReadReg2=2 -> ReadData1=0xA5A5A5A5, ReadData2=0x5A5A5A5A in the same cycle.
//   6. WE gating and reset mid-run:
//        - WE=0, WriteReg=3, WriteData=0x12345678 across an edge -> r3 reads 0.
//        - Then pulse rst between edges -> r1 and r2 read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and the hard-wired $zero index.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file, with the $zero override.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    // $zero reads 0 no matter what the storage holds; no write-to-read bypass.
    assign data = (addr == ADDR_WIDTH'(ZERO_REG)) ? '0 : regs[addr];

endmodule : regfile_read_port

// File: rtl/registers_block.sv
// MIPS general-purpose register file: 32 x 32-bit, two asynchronous reads, one synchronous write.
module registers_block
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // NOTE: the whole array is flop-based and cleared by the async reset so no entry is ever X;
    // this is why it cannot map onto a RAM macro. Non-blocking updates keep the write
    // edge-accurate, so a same-cycle read still sees the old value before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (WE && (WriteReg != ADDR_WIDTH'(ZERO_REG))) begin
            regs[WriteReg] <= WriteData;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port1 (
        .regs(regs),
        .addr(ReadReg1),
        .data(ReadData1)
    );

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port2 (
        .regs(regs),
        .addr(ReadReg2),
        .data(ReadData2)
    );

endmodule : registers_block

// File: tb/tb_registers_block.sv
// Scoreboard bench for registers_block: directed scenarios plus randomized writes/reads vs an array model.
module tb_registers_block;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WE = 1'b0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    registers_block dut (
        .clk(clk),
        .rst(rst),
        .WE(WE),
        .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] model [32];

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic expect_port(input string name, input bit port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.port = port;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Monitor: pops expectations and compares against the live read outputs.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            wait (exp_q.size() != 0);
            e   = exp_q.pop_front();
            act = e.port ? ReadData2 : ReadData1;
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port + 1, act, e.exp);
            end
        end
    end

    task automatic read_check(input logic [4:0] a1, input logic [4:0] a2, input string name);
        ReadReg1 = a1;
        ReadReg2 = a2;
        #1;
        expect_port(name, 1'b0, model_read(a1));
        expect_port(name, 1'b1, model_read(a2));
        #1;
    endtask

    // Write across one edge; port 1 watches the target to see old-before / new-after the edge.
    task automatic do_write(input logic we, input logic [4:0] a, input logic [31:0] d, input string name);
        @(negedge clk);
        WE        = we;
        WriteReg  = a;
        WriteData = d;
        ReadReg1  = a;
        #1;
        expect_port({name, "_before"}, 1'b0, model_read(a));
        @(posedge clk);
        if (we && !rst && a != 5'd0) model[a] = d;
        #1;
        expect_port({name, "_after"}, 1'b0, model_read(a));
        WE = 1'b0;
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        model_clear();
        #1;
        read_check(5'd7, 5'd31, "in_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) read_check(5'(i), 5'(31 - i), "reset_all");

        do_write(1'b1, 5'd1, 32'hA5A5_A5A5, "wr_r1");
        read_check(5'd1, 5'd0, "rd_r1");
        do_write(1'b1, 5'd2, 32'h5A5A_5A5A, "wr_r2");
        read_check(5'd1, 5'd2, "rd_r1_r2");
        do_write(1'b1, 5'd0, 32'hFFFF_FFFF, "wr_zero");
        read_check(5'd0, 5'd0, "rd_zero");
        read_check(5'd2, 5'd1, "dual_swap");
        do_write(1'b0, 5'd3, 32'h1234_5678, "we_off");
        read_check(5'd3, 5'd3, "rd_r3");
        do_write(1'b1, 5'd31, 32'hDEAD_BEEF, "wr_r31");

        // Reset pulse between edges clears contents before the next edge.
        @(negedge clk);
        #1 rst = 1'b1;
        model_clear();
        read_check(5'd1, 5'd2, "mid_reset");
        read_check(5'd31, 5'd31, "mid_reset_r31");
        #1 rst = 1'b0;
        read_check(5'd1, 5'd2, "post_reset");

        // Write attempted while rst is held across the edge must be blocked.
        rst = 1'b1;
        do_write(1'b1, 5'd4, 32'hCAFE_F00D, "wr_in_reset");
        rst = 1'b0;
        read_check(5'd4, 5'd4, "rd_r4_blocked");

        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            do_write(1'($urandom_range(0, 3) != 0), wa, $urandom, "rand_wr");
            read_check(5'($urandom), 5'($urandom), "rand_rd");
        end
        for (int i = 0; i < 32; i++) read_check(5'(i), 5'(i ^ 5'h15), "final_sweep");

        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_registers_block
